// File: rtl/baudgen_frac.sv
// Fractional-N baud tick generator: oversample and bit strobes from a runtime
// integer+fraction divisor, with mid-bit re-phasing for UART receivers.
module baudgen_frac #(
  parameter int CNT_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int DIV_INT_RST  = 3,
  parameter int DIV_FRAC_RST = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    clk_ena,
  input  logic                    half_start,
  input  logic                    div_load,
  input  logic [CNT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    ovs_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  ovs_phase
);

  localparam int PH_W = $clog2(OVS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              run_q, run_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  ai_q, ai_d, sai_q, sai_d;
  logic [FRAC_W-1:0] af_q, af_d, saf_q, saf_d;

  logic              tick, rephase, apply;
  logic [CNT_W-1:0]  ni, ai_sel, ai_e;
  logic [FRAC_W-1:0] nf, af_sel;
  logic [FRAC_W:0]   acc_sum;

  assign tick    = run_q & clk_ena & ~half_start & (cnt_q == '0);
  assign rephase = clk_ena & half_start;

  // A load in the same cycle as an apply point bypasses the shadow registers.
  assign ni      = div_load ? div_int  : sai_q;
  assign nf      = div_load ? div_frac : saf_q;
  assign apply   = (tick | rephase | ~clk_ena) & (div_load | pend_q);
  assign ai_sel  = apply ? ni : ai_q;
  assign af_sel  = apply ? nf : af_q;
  assign ai_e    = (ai_sel == '0) ? CNT_W'(1) : ai_sel;
  assign acc_sum = {1'b0, acc_q} + {1'b0, af_sel};

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    run_d   = run_q;
    pend_d  = pend_q;
    sai_d   = sai_q;
    saf_d   = saf_q;
    ai_d    = ai_sel;
    af_d    = af_sel;
    if (div_load) begin
      sai_d  = div_int;
      saf_d  = div_frac;
      pend_d = 1'b1;
    end
    if (apply) pend_d = 1'b0;
    if (!clk_ena) begin
      cnt_d   = '0;
      acc_d   = '0;
      phase_d = PH_W'(OVS - 1);
      run_d   = 1'b0;
    end else begin
      run_d = 1'b1;
      if (rephase) begin
        cnt_d   = ai_e - CNT_W'(1);
        acc_d   = '0;
        phase_d = PH_W'(OVS / 2);
      end else if (tick) begin
        // Carry out of the fraction stretches this period by one clock.
        cnt_d   = ai_e - CNT_W'(1) + {{(CNT_W-1){1'b0}}, acc_sum[FRAC_W]};
        acc_d   = acc_sum[FRAC_W-1:0];
        phase_d = phase_q + PH_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      phase_q <= PH_W'(OVS - 1);
      run_q   <= 1'b0;
      pend_q  <= 1'b0;
      ai_q    <= CNT_W'(DIV_INT_RST);
      af_q    <= FRAC_W'(DIV_FRAC_RST);
      sai_q   <= CNT_W'(DIV_INT_RST);
      saf_q   <= FRAC_W'(DIV_FRAC_RST);
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      ai_q    <= ai_d;
      af_q    <= af_d;
      sai_q   <= sai_d;
      saf_q   <= saf_d;
    end
  end

  assign ovs_tick  = tick;
  assign bit_tick  = tick & (phase_q == PH_W'(OVS - 1));
  assign ovs_phase = phase_q;

endmodule
